// File: rtl/bamse_irqc_pkg.sv
// bamse_irqc shared definitions: register offsets, FSM encodings, priority helper.
// Optional feature macro used by the top: IRQC_AUTO_EOI_EN.
package bamse_irqc_pkg;

    localparam logic [1:0] IRQC_PENDING = 2'd0;
    localparam logic [1:0] IRQC_MASK    = 2'd1;
    localparam logic [1:0] IRQC_VECTOR  = 2'd2;
    localparam logic [1:0] IRQC_SOFT    = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SVC  = 2'd2;

    // Index 0 has the highest priority.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/irqc_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector.
// evt is a one-cycle pulse per synchronised low-to-high transition.
module irqc_sync_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] evt
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;
    logic [W-1:0] prev_q, prev_d;

    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign evt = s2_q & ~prev_q;

endmodule

// File: rtl/bamse_irqc.sv
// Port-mapped fixed-priority interrupt controller for the bamse PicoBlaze3 system.
// Define IRQC_AUTO_EOI_EN to drop the SVC state and retire requests on ack.
module bamse_irqc
    import bamse_irqc_pkg::*;
#(
    parameter int         N_SRC     = 8,
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [7:0]       port_id,
    input  logic [7:0]       out_port,
    input  logic             write_strobe,
    input  logic             read_strobe,
    output logic [7:0]       data_out,
    output logic             hit,
    output logic             interrupt,
    input  logic             interrupt_ack
);

    localparam logic [7:0] SRC_MASK = 8'((9'd1 << N_SRC) - 9'd1);

    logic [N_SRC-1:0] evt;
    logic [7:0]       evt8;

    irqc_sync_edge #(.W(N_SRC)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (irq_src),
        .evt   (evt)
    );

    always_comb begin
        evt8             = '0;
        evt8[N_SRC-1:0]  = evt;
    end

    logic [7:0] pending_q, pending_d;
    logic [7:0] mask_q, mask_d;
    logic [1:0] state_q, state_d;
    logic [2:0] id_q, id_d;
    logic       irq_q, irq_d;
    logic       vvalid_q, vvalid_d;
    logic [2:0] vid_q, vid_d;
    logic [7:0] data_q, data_d;
    logic       hit_q, hit_d;

    logic [7:0] off;
    logic       in_range;
    logic [1:0] sel;
    logic       wr_pend, wr_mask, wr_soft;
    logic [7:0] active;

    assign off      = port_id - BASE_ADDR;
    assign in_range = off < 8'd4;
    assign sel      = off[1:0];
    assign wr_pend  = write_strobe & in_range & (sel == IRQC_PENDING);
    assign wr_mask  = write_strobe & in_range & (sel == IRQC_MASK);
    assign wr_soft  = write_strobe & in_range & (sel == IRQC_SOFT);
    assign active   = pending_q & mask_q;

`ifndef IRQC_AUTO_EOI_EN
    logic wr_vec;
    assign wr_vec = write_strobe & in_range & (sel == IRQC_VECTOR);
`endif

    always_comb begin
        pending_d = pending_q;
        mask_d    = mask_q;
        state_d   = state_q;
        id_d      = id_q;
        irq_d     = irq_q;
        vvalid_d  = vvalid_q;
        vid_d     = vid_q;

        if (wr_mask) mask_d = out_port & SRC_MASK;
        if (wr_pend) pending_d = pending_d & ~out_port;
        if (wr_soft) pending_d = pending_d | out_port;

        case (state_q)
            ST_IDLE: begin
                if (|active) begin
                    id_d    = lowest_set(active);
                    irq_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (interrupt_ack) begin
                    pending_d[id_q] = 1'b0;
                    vvalid_d        = 1'b1;
                    vid_d           = id_q;
                    irq_d           = 1'b0;
`ifdef IRQC_AUTO_EOI_EN
                    state_d         = ST_IDLE;
`else
                    state_d         = ST_SVC;
`endif
                end else if (!active[id_q]) begin
                    irq_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
`ifndef IRQC_AUTO_EOI_EN
            ST_SVC: begin
                if (wr_vec) begin
                    vvalid_d = 1'b0;
                    vid_d    = 3'd0;
                    state_d  = ST_IDLE;
                end
            end
`endif
            default: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // A new edge beats any clear landing in the same cycle.
        pending_d = (pending_d | evt8) & SRC_MASK;
    end

    always_comb begin
        data_d = 8'h00;
        if (in_range) begin
            case (sel)
                IRQC_PENDING: data_d = pending_q;
                IRQC_MASK:    data_d = mask_q;
                IRQC_VECTOR:  data_d = {vvalid_q, 4'b0000, vid_q};
                default:      data_d = 8'h00;
            endcase
        end
        // Reads have no side effects, so read_strobe never qualifies anything.
        hit_d = in_range | (read_strobe & 1'b0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            mask_q    <= '0;
            state_q   <= ST_IDLE;
            id_q      <= '0;
            irq_q     <= 1'b0;
            vvalid_q  <= 1'b0;
            vid_q     <= '0;
            data_q    <= '0;
            hit_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            state_q   <= state_d;
            id_q      <= id_d;
            irq_q     <= irq_d;
            vvalid_q  <= vvalid_d;
            vid_q     <= vid_d;
            data_q    <= data_d;
            hit_q     <= hit_d;
        end
    end

    assign interrupt = irq_q;
    assign data_out  = data_q;
    assign hit       = hit_q;

endmodule
